dma_axi_master: RTL

- AXI4 initiator half of the DMA engine. It receives DMAEN/DMASRC/DMADST/DMALEN from the DMA slave register file and moves LEN 32-bit words from SRC to DST.
- Each chunk is one INCR read burst into an internal buffer, followed by one INCR write burst out of that buffer.
- Connects to one master port of the AXI interconnect.

---
 rtl/dma_axi_master.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/dma_axi_master.sv
// AXI4 read-then-write DMA initiator: copies LEN words SRC->DST in INCR bursts
// split on MAX_BURST and on 4 KB boundaries of either address, staged through a local buffer.
module dma_axi_master #(
  parameter int ID_W      = 4,
  parameter int MAX_BURST = 16,
  parameter int MASTER_ID = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [31:0]     src_addr,
  input  logic [31:0]     dst_addr,
  input  logic [31:0]     len,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [ID_W-1:0] ARID,
  output logic [31:0]     ARADDR,
  output logic [7:0]      ARLEN,
  output logic [2:0]      ARSIZE,
  output logic [1:0]      ARBURST,
  output logic            ARVALID,
  input  logic            ARREADY,
  input  logic [ID_W-1:0] RID,
  input  logic [31:0]     RDATA,
  input  logic [1:0]      RRESP,
  input  logic            RLAST,
  input  logic            RVALID,
  output logic            RREADY,
  output logic [ID_W-1:0] AWID,
  output logic [31:0]     AWADDR,
  output logic [7:0]      AWLEN,
  output logic [2:0]      AWSIZE,
  output logic [1:0]      AWBURST,
  output logic            AWVALID,
  input  logic            AWREADY,
  output logic [31:0]     WDATA,
  output logic [3:0]      WSTRB,
  output logic            WLAST,
  output logic            WVALID,
  input  logic            WREADY,
  input  logic [ID_W-1:0] BID,
  input  logic [1:0]      BRESP,
  input  logic            BVALID,
  output logic            BREADY
);

  localparam int IDX_W = $clog2(MAX_BURST) + 1;
  localparam int AW    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_RADDR, S_RDATA, S_WADDR, S_WDATA, S_WRESP, S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      cur_src_q, cur_src_d;
  logic [31:0]      cur_dst_q, cur_dst_d;
  logic [31:0]      remain_q, remain_d;
  logic [IDX_W-1:0] beats_q, beats_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic [31:0]      mem_q [MAX_BURST];
  logic             mem_we;

  logic [IDX_W-1:0] beats_m1;
  logic             idx_last;
  logic [31:0]      beats_bytes;
  logic [31:0]      src_room, dst_room, burst_calc;
  logic             unused_ok;

  assign beats_m1    = beats_q - IDX_W'(1);
  assign idx_last    = (idx_q == beats_m1);
  assign beats_bytes = {{(32-IDX_W){1'b0}}, beats_q} << 2;
  assign unused_ok   = ^{RID, BID, src_addr[1:0], dst_addr[1:0]};

  // Words left before each address crosses its next 4 KB page.
  always_comb begin
    src_room   = (32'h1000 - {20'd0, cur_src_q[11:0]}) >> 2;
    dst_room   = (32'h1000 - {20'd0, cur_dst_q[11:0]}) >> 2;
    burst_calc = remain_q;
    if (burst_calc > 32'(MAX_BURST)) burst_calc = 32'(MAX_BURST);
    if (burst_calc > src_room)       burst_calc = src_room;
    if (burst_calc > dst_room)       burst_calc = dst_room;
  end

  always_comb begin
    state_d   = state_q;
    cur_src_d = cur_src_q;
    cur_dst_d = cur_dst_q;
    remain_d  = remain_q;
    beats_d   = beats_q;
    idx_d     = idx_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_src_d = {src_addr[31:2], 2'b00};
          cur_dst_d = {dst_addr[31:2], 2'b00};
          remain_d  = len;
          err_d     = 1'b0;
          state_d   = (len == 32'd0) ? S_FIN : S_CALC;
        end
      end
      S_CALC: begin
        beats_d = burst_calc[IDX_W-1:0];
        idx_d   = '0;
        state_d = S_RADDR;
      end
      S_RADDR: if (ARREADY) state_d = S_RDATA;
      S_RDATA: begin
        if (RVALID) begin
          mem_we = 1'b1;
          idx_d  = idx_q + IDX_W'(1);
          if (RRESP != 2'b00)    err_d = 1'b1;
          if (RLAST != idx_last) err_d = 1'b1;
          // Whichever of RLAST or the beat count arrives first closes the read.
          if (RLAST || idx_last) begin
            idx_d   = '0;
            state_d = S_WADDR;
          end
        end
      end
      S_WADDR: if (AWREADY) state_d = S_WDATA;
      S_WDATA: begin
        if (WREADY) begin
          if (idx_last) begin
            idx_d   = '0;
            state_d = S_WRESP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_WRESP: begin
        if (BVALID) begin
          if (BRESP != 2'b00) err_d = 1'b1;
          cur_src_d = cur_src_q + beats_bytes;
          cur_dst_d = cur_dst_q + beats_bytes;
          remain_d  = remain_q - {{(32-IDX_W){1'b0}}, beats_q};
          state_d   = (remain_d == 32'd0 || err_d) ? S_FIN : S_CALC;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cur_src_q <= '0;
      cur_dst_q <= '0;
      remain_q  <= '0;
      beats_q   <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_src_q <= cur_src_d;
      cur_dst_q <= cur_dst_d;
      remain_q  <= remain_d;
      beats_q   <= beats_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[idx_q[AW-1:0]] <= RDATA;
  end

  // Payloads are zeroed outside their phase so reset and idle look identical on the bus.
  assign ARVALID = (state_q == S_RADDR);
  assign ARADDR  = ARVALID ? cur_src_q : '0;
  assign ARLEN   = ARVALID ? 8'(beats_m1) : '0;
  assign ARID    = ID_W'(MASTER_ID);
  assign ARSIZE  = 3'b010;
  assign ARBURST = 2'b01;
  assign RREADY  = (state_q == S_RDATA);

  assign AWVALID = (state_q == S_WADDR);
  assign AWADDR  = AWVALID ? cur_dst_q : '0;
  assign AWLEN   = AWVALID ? 8'(beats_m1) : '0;
  assign AWID    = ID_W'(MASTER_ID);
  assign AWSIZE  = 3'b010;
  assign AWBURST = 2'b01;

  assign WVALID  = (state_q == S_WDATA);
  assign WDATA   = WVALID ? mem_q[idx_q[AW-1:0]] : '0;
  assign WLAST   = WVALID && idx_last;
  assign WSTRB   = 4'hF;
  assign BREADY  = (state_q == S_WRESP);

  assign busy = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done = (state_q == S_FIN);
  assign err  = err_q;

endmodule
